sw_led_ctrl: RTL
================

SW_LED_CTRL -- requirements
Module: sw_led_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, number of switch/LED channels (1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 16, debounce stability window in clock cycles (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 8, blink half-period in clock cycles (>=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sw  input  N  raw asynchronous switch levels.
REQ-007 SHALL have port mode  input  2  display mode select; sampled every cycle.
REQ-008 SHALL have port clr  input  1  synchronous clear of toggle latches.
REQ-009 SHALL have port led  output  N  registered LED drive.
REQ-010 SHALL have port sw_stable  output  N  debounced switch levels.

Function
REQ-011 SHALL pass each sw bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep per channel a counter of width clog2(DB_CYCLES); counter clears whenever synchronized bit equals sw_stable bit.
REQ-013 SHALL increment counter while synchronized bit differs from sw_stable; at count DB_CYCLES-1 with difference still present, sw_stable bit SHALL flip and counter SHALL clear same cycle.
REQ-014 SHALL ensure a sw change held steady appears on sw_stable exactly DB_CYCLES+2 cycles later, and on led (direct mode) one cycle after that.
REQ-015 SHALL reject glitches: any return to the stable level before the window completes restarts the count, sw_stable unchanged.
REQ-016 SHALL generate a one-cycle internal rise pulse per channel on sw_stable 0->1.
REQ-017 SHALL, in mode 2'b00 (DIRECT), drive led = sw_stable, registered.
REQ-018 SHALL, in mode 2'b01 (TOGGLE), drive led = toggle latch; each latch flips on its channel rise pulse.
REQ-019 SHALL, in mode 2'b10 (BLINK), drive led = sw_stable AND blink_phase.
REQ-020 SHALL treat mode 2'b11 as reserved, behaving as DIRECT.
REQ-021 SHALL run a free-running blink counter toggling blink_phase every BLINK_DIV cycles, wrapping to 0, independent of mode.
REQ-022 SHALL update toggle latches on rise pulses in every mode; mode changes never alter latch contents.
REQ-023 SHALL give clr priority over a simultaneous rise pulse: all latches 0 next cycle.
REQ-024 SHALL apply a mode change to led on the next clock edge (one-cycle latency).

Reset
REQ-025 SHALL, while rstn low, asynchronously force led, sw_stable, synchronizer flops, debounce counters, toggle latches, blink counter and blink_phase to 0.
REQ-026 SHALL, after rstn deasserts, treat any sw bit already high as a fresh 0->1 change (debounced, then rise pulse).
REQ-027 SHALL abandon any in-progress debounce count when reset asserts mid-window.

Configuration
REQ-028 SHALL compile blink counter and BLINK mode only when macro SW_LED_BLINK_EN is defined.
REQ-029 SHALL, without SW_LED_BLINK_EN, omit blink logic and treat mode 2'b10 as DIRECT; BLINK_DIV then unused.

Structure
REQ-030 SHALL place mode encodings (MODE_DIRECT, MODE_TOGGLE, MODE_BLINK, MODE_RSVD) in shared package sw_led_pkg.
REQ-031 SHALL implement synchronizer plus debounce for one channel in sub-module sw_debounce, instantiated N times via generate.

Verification (N=8, DB_CYCLES=4, BLINK_DIV=4)
REQ-032 SHALL check: reset, mode=00, sw 00->0x01 held -> sw_stable=0x01 after 6 cycles, led=0x01 after 7.
REQ-033 SHALL check: sw[1] pulsed high 3 cycles then low -> sw_stable and led stay 0x00.
REQ-034 SHALL check: mode=01, sw 0x03 -> 0x00 -> 0x03 (each held 10 cycles) -> led 0x03, 0x03, 0x00.
REQ-035 SHALL check: mode=10, sw=0x81 stable -> led alternates 0x81/0x00 every 4 cycles; undefined macro -> led constant 0x81.
REQ-036 SHALL check: clr asserted same cycle as sw[3] rise pulse in mode=01 -> latches 0x00, led 0x00.
REQ-037 SHALL check: rstn pulsed low mid-debounce of sw=0x0B -> all outputs 0 immediately; after release sw_stable=0x0B 6 cycles later.

Source files
------------

// File: rtl/sw_led_pkg.sv
// -----------------------------------------------------------------------------
// sw_led_pkg
// Shared definitions for the switch/LED controller.
//   mode_e : display mode encodings carried on the 2-bit mode input
//            MODE_DIRECT (00) - LEDs follow the debounced switches
//            MODE_TOGGLE (01) - LEDs show per-channel toggle latches
//            MODE_BLINK  (10) - LEDs show switches gated by the blink phase
//                               (only when SW_LED_BLINK_EN is defined,
//                               otherwise behaves as DIRECT)
//            MODE_RSVD   (11) - reserved, behaves as DIRECT
// -----------------------------------------------------------------------------
package sw_led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Width of a counter that must hold values 0..count-1 (at least 1 bit).
    function automatic int cnt_width(input int count);
        return (count > 2) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// One switch channel: 2-flop synchronizer followed by a stability-window
// debouncer. The stable level flips only after the synchronized level has
// differed from it for DB_CYCLES consecutive clocks; any return to the stable
// level restarts the window.
//   clk       : system clock, rising edge
//   rstn      : asynchronous active-low reset
//   sw        : raw asynchronous switch level
//   sw_stable : debounced level
// Latency of a held change: 2 (sync) + DB_CYCLES clocks.
// -----------------------------------------------------------------------------
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic sw,
    output logic sw_stable
);

    localparam int              CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic          stable_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            sync1_reg <= sw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == stable_reg) begin
                // Back at the stable level: abandon any partial window.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Window complete with the difference still present.
                stable_reg <= ~stable_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign sw_stable = stable_reg;

endmodule

// File: rtl/sw_led_ctrl.sv
// -----------------------------------------------------------------------------
// sw_led_ctrl
// N-channel switch debouncer and LED driver with selectable display mode.
//   clk       : system clock, rising edge
//   rstn      : asynchronous active-low reset
//   sw        : [N-1:0] raw asynchronous switch levels
//   mode      : [1:0] display mode (see sw_led_pkg::mode_e), sampled each cycle
//   clr       : synchronous clear of all toggle latches (beats a rise pulse)
//   led       : [N-1:0] registered LED drive
//   sw_stable : [N-1:0] debounced switch levels
// Build option: define SW_LED_BLINK_EN to include the blink counter and the
// BLINK mode; without it mode 2'b10 shows the debounced switches directly and
// BLINK_DIV has no effect.
// -----------------------------------------------------------------------------
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int N         = 8,
    parameter int DB_CYCLES = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N-1:0]         sw,
    input  logic [MODE_W-1:0]    mode,
    input  logic                 clr,
    output logic [N-1:0]         led,
    output logic [N-1:0]         sw_stable
);

    logic [N-1:0] stable_d_reg;
    logic [N-1:0] rise;
    logic [N-1:0] toggle_reg;
    logic [N-1:0] led_reg;
    logic [N-1:0] led_next;
    mode_e        mode_sel;

    // Per-channel synchronizer + debouncer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            sw_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .rstn      (rstn),
                .sw        (sw[gi]),
                .sw_stable (sw_stable[gi])
            );
        end
    endgenerate

    // One-cycle pulse on each debounced 0->1 transition. Because stable_d_reg
    // resets to 0, a switch already high at reset release produces a pulse
    // once it has been debounced.
    assign rise = sw_stable & ~stable_d_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_d_reg <= '0;
            toggle_reg   <= '0;
        end else begin
            stable_d_reg <= sw_stable;
            // Latches track rise pulses regardless of mode; clr wins.
            if (clr) begin
                toggle_reg <= '0;
            end else begin
                toggle_reg <= toggle_reg ^ rise;
            end
        end
    end

`ifdef SW_LED_BLINK_EN
    localparam int            BW        = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_reg;
    logic          blink_phase_reg;

    // Free-running; phase flips once every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end
`else
    // Blink hardware is absent; keep the parameter referenced.
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 1);
`endif

    assign mode_sel = mode_e'(mode);

    always_comb begin
        led_next = sw_stable;
        case (mode_sel)
            MODE_TOGGLE: led_next = toggle_reg;
`ifdef SW_LED_BLINK_EN
            MODE_BLINK:  led_next = sw_stable & {N{blink_phase_reg}};
`endif
            default:     led_next = sw_stable;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led = led_reg;

endmodule
